// File: rtl/bcd.sv
// Single-digit BCD up-counter with synchronous load, wrap carry and a
// built-in seven-segment decoder (seg[0]=a ... seg[6]=g).
module bcd #(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_syn,
  input  logic       load_syn,
  input  logic [3:0] Din,
  output logic [3:0] q,
  output logic       carry,
  output logic [6:0] seg
);

  logic [6:0] seg_raw;

  // Load beats counting; out-of-range values (bad load or upset) collapse to 0
  always_ff @(posedge clk or negedge rst_syn) begin
    if (!rst_syn) begin
      q     <= 4'd0;
      carry <= 1'b0;
    end else if (load_syn) begin
      q     <= (Din > 4'd9) ? 4'd0 : Din;
      carry <= 1'b0;
    end else if (q == 4'd9) begin
      q     <= 4'd0;
      carry <= 1'b1;
    end else if (q > 4'd9) begin
      q     <= 4'd0;
      carry <= 1'b0;
    end else begin
      q     <= q + 4'd1;
      carry <= 1'b0;
    end
  end

  always_comb begin
    seg_raw = 7'h00;
    case (q)
      4'd0:    seg_raw = 7'h3F;
      4'd1:    seg_raw = 7'h06;
      4'd2:    seg_raw = 7'h5B;
      4'd3:    seg_raw = 7'h4F;
      4'd4:    seg_raw = 7'h66;
      4'd5:    seg_raw = 7'h6D;
      4'd6:    seg_raw = 7'h7D;
      4'd7:    seg_raw = 7'h07;
      4'd8:    seg_raw = 7'h7F;
      4'd9:    seg_raw = 7'h6F;
      default: seg_raw = 7'h00;
    endcase
  end

  assign seg = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;

endmodule

// File: tb/tb_bcd.sv
// Directed bench for bcd: active-high and active-low builds share stimulus;
// a mod-10 reference model is checked every falling edge.
module tb_bcd;

  logic       clk = 1'b0;
  logic       rst_syn;
  logic       load_syn;
  logic [3:0] Din;
  logic [3:0] q, q_lo;
  logic       carry, carry_lo;
  logic [6:0] seg, seg_lo;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] m_q = 4'd0;
  logic       m_carry = 1'b0;
  logic       model_on = 1'b0;
  logic [6:0] seg_tab [0:9];

  bcd #(.SEG_ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst_syn(rst_syn), .load_syn(load_syn), .Din(Din),
    .q(q), .carry(carry), .seg(seg)
  );

  bcd #(.SEG_ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst_syn(rst_syn), .load_syn(load_syn), .Din(Din),
    .q(q_lo), .carry(carry_lo), .seg(seg_lo)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    return (v <= 4'd9) ? seg_tab[v] : 7'h00;
  endfunction

  task automatic check_output(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic ld, input logic [3:0] d);
    load_syn = ld;
    Din      = d;
  endtask

  // Reference: a decimal digit that counts modulo ten
  always @(posedge clk or negedge rst_syn) begin
    if (!rst_syn) begin
      m_q     <= 4'd0;
      m_carry <= 1'b0;
    end else if (load_syn) begin
      m_q     <= (Din > 4'd9) ? 4'd0 : Din;
      m_carry <= 1'b0;
    end else begin
      m_q     <= 4'(({28'd0, m_q} + 32'd1) % 32'd10);
      m_carry <= (m_q == 4'd9);
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check_output("model_q",        {4'd0, q},        {4'd0, m_q});
      check_output("model_carry",    {7'd0, carry},    {7'd0, m_carry});
      check_output("model_seg",      {1'b0, seg},      {1'b0, seg_of(m_q)});
      check_output("model_q_lo",     {4'd0, q_lo},     {4'd0, m_q});
      check_output("model_carry_lo", {7'd0, carry_lo}, {7'd0, m_carry});
      check_output("model_seg_lo",   {1'b0, seg_lo},   {1'b0, ~seg_of(m_q)});
    end
  end

  initial begin
    logic [3:0] cnt_q [0:11];
    logic       cnt_c [0:11];
    logic [3:0] run_q [0:4];
    seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
    seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
    seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;
    cnt_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    cnt_c = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    run_q = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd0};

    rst_syn = 1'b0;
    apply_stimulus(1'b0, 4'd0);
    repeat (2) @(posedge clk);
    #2 rst_syn = 1'b1;
    model_on = 1'b1;
    repeat (3) @(posedge clk);

    // Reset mid-cycle while a load is requested
    #2 rst_syn = 1'b0;
    apply_stimulus(1'b1, 4'd5);
    #1;
    check_output("rst_q",      {4'd0, q},        8'h00);
    check_output("rst_carry",  {7'd0, carry},    8'h00);
    check_output("rst_seg",    {1'b0, seg},      8'h3F);
    check_output("rst_seg_lo", {1'b0, seg_lo},   8'h40);
    @(posedge clk); #1;
    check_output("rst_hold_q", {4'd0, q}, 8'h00);
    apply_stimulus(1'b0, 4'd0);
    @(posedge clk); #2 rst_syn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check_output("count_q",     {4'd0, q},     {4'd0, cnt_q[i]});
      check_output("count_carry", {7'd0, carry}, {7'd0, cnt_c[i]});
      check_output("count_seg",   {1'b0, seg},   {1'b0, seg_tab[cnt_q[i]]});
    end

    #1 apply_stimulus(1'b1, 4'b0101);
    @(posedge clk); #1;
    check_output("load5_q",   {4'd0, q},   8'h05);
    check_output("load5_seg", {1'b0, seg}, 8'h6D);
    apply_stimulus(1'b0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_output("run_q",     {4'd0, q},     {4'd0, run_q[i]});
      check_output("run_carry", {7'd0, carry}, (i == 4) ? 8'h01 : 8'h00);
    end

    apply_stimulus(1'b1, 4'd9);
    @(posedge clk); #1;
    check_output("load9_q",     {4'd0, q},     8'h09);
    check_output("load9_carry", {7'd0, carry}, 8'h00);
    apply_stimulus(1'b0, 4'd0);
    @(posedge clk); #1;
    check_output("wrap_q",     {4'd0, q},     8'h00);
    check_output("wrap_carry", {7'd0, carry}, 8'h01);
    apply_stimulus(1'b1, 4'd8);
    @(posedge clk); #1;
    apply_stimulus(1'b0, 4'd0);
    @(posedge clk); #1;
    check_output("at9_q", {4'd0, q}, 8'h09);
    apply_stimulus(1'b1, 4'd3);
    @(posedge clk); #1;
    check_output("ovr_q",     {4'd0, q},     8'h03);
    check_output("ovr_carry", {7'd0, carry}, 8'h00);

    apply_stimulus(1'b1, 4'hC);
    @(posedge clk); #1;
    check_output("badbcd_q",     {4'd0, q},     8'h00);
    check_output("badbcd_carry", {7'd0, carry}, 8'h00);
    apply_stimulus(1'b1, 4'd7);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_output("frozen_q", {4'd0, q}, 8'h07);
    end

    apply_stimulus(1'b1, 4'd8);
    @(posedge clk); #1;
    check_output("q8_seg",    {1'b0, seg},    8'h7F);
    check_output("q8_seg_lo", {1'b0, seg_lo}, 8'h00);
    apply_stimulus(1'b1, 4'd6);
    @(posedge clk); #1;
    check_output("q6_q", {4'd0, q_lo}, 8'h06);
    apply_stimulus(1'b0, 4'd0);
    #1 rst_syn = 1'b0;
    #1;
    check_output("async_q_lo",   {4'd0, q_lo},   8'h00);
    check_output("async_seg_lo", {1'b0, seg_lo}, 8'h40);

    repeat (2) @(posedge clk);
    #1 model_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
